// File: rtl/inert_intf_multi.sv
// inert_intf_multi
//   Multi-axis inertial sensor interface. Drives a 16-bit SPI master link
//   (mode 3: SCLK idles high, MOSI changes on SCLK fall, MISO sampled on
//   SCLK rise), waits 2^PWRUP_W cycles after reset, writes the four
//   configuration registers, then on every synchronised INT rising edge
//   burst-reads NUM_AXES signed 16-bit axes (low byte then high byte).
//   Samples are box-car averaged over 2^AVG_LOG2 bursts before being shown.
//
//   Output handshake: there is no back-pressure. vld is a one-cycle pulse
//   that coincides with new contents on data; data holds until the next
//   pulse. ovr is a one-cycle pulse for an INT edge dropped mid-burst.
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   INT        : sensor data-ready (asynchronous)
//   MISO       : SPI data from sensor
//   SS_n, SCLK, MOSI : SPI master outputs
//   init_done  : configuration writes complete (sticky until rst)
//   vld        : one-cycle data-updated pulse
//   data       : packed signed axes, axis k at data[16k+15:16k]
//   ovr        : one-cycle overrun pulse
module inert_intf_multi #(
    parameter int         NUM_AXES  = 3,
    parameter logic [6:0] AXIS_BASE = 7'h22,
    parameter int         AVG_LOG2  = 0,
    parameter int         SCLK_DIV  = 16,
    parameter int         PWRUP_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     INT,
    input  logic                     MISO,
    output logic                     SS_n,
    output logic                     SCLK,
    output logic                     MOSI,
    output logic                     init_done,
    output logic                     vld,
    output logic [NUM_AXES*16-1:0]   data,
    output logic                     ovr
);

    localparam int          HALF      = SCLK_DIV / 2;
    localparam int          NBYTES    = 2 * NUM_AXES;
    localparam int          AW        = 16 + AVG_LOG2;
    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);
    localparam logic [2:0]  BIDX_LAST = 3'(NBYTES - 1);
    localparam logic [4:0]  SMP_LAST  = 5'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_CFG   = 3'd1,
        S_IDLE  = 3'd2,
        S_RD    = 3'd3,
        S_ACC   = 3'd4
    } state_t;

    // state_q is the observable FSM state for bound checkers
    state_t state_q, state_d;

    function automatic logic [15:0] cfg_word(input logic [1:0] idx);
        case (idx)
            2'd0:    cfg_word = 16'h0D02;
            2'd1:    cfg_word = 16'h1053;
            2'd2:    cfg_word = 16'h1150;
            default: cfg_word = 16'h1460;
        endcase
    endfunction

    // INT synchroniser and rising-edge detect
    logic int_s1_q, int_s2_q, int_s3_q;
    logic int_edge;
    assign int_edge = int_s2_q & ~int_s3_q;

    // SPI frame engine. A frame is 35 half-SCLK phases:
    //   0      : SS_n low, lead-in
    //   1..32  : odd phase ends with SCLK rise, even phase ends with fall
    //   32 end : SS_n rises
    //   33,34  : inter-frame gap of SCLK_DIV cycles with SS_n high
    logic        busy_q;
    logic [5:0]  ph_q;
    logic [15:0] hc_q;
    logic [15:0] tx_q, rx_q;
    logic        ss_n_q, sclk_q, mosi_q;
    logic        half_end, spi_done;
    logic        start_frame;
    logic [15:0] frame_word;

    assign half_end = busy_q && (hc_q == HALF_LAST);
    assign spi_done = half_end && (ph_q == 6'd34);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            ph_q   <= '0;
            hc_q   <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
            ss_n_q <= 1'b1;
            sclk_q <= 1'b1;
            mosi_q <= 1'b0;
        end else if (start_frame) begin
            busy_q <= 1'b1;
            ss_n_q <= 1'b0;
            ph_q   <= '0;
            hc_q   <= '0;
            tx_q   <= frame_word;
        end else if (busy_q) begin
            if (half_end) begin
                hc_q <= '0;
                ph_q <= ph_q + 6'd1;
                if (ph_q == 6'd34) begin
                    busy_q <= 1'b0;
                end else if (ph_q == 6'd32) begin
                    ss_n_q <= 1'b1;
                    mosi_q <= 1'b0;
                end else if (ph_q < 6'd32) begin
                    if (ph_q[0]) begin
                        sclk_q <= 1'b1;
                        rx_q   <= {rx_q[14:0], MISO};
                    end else begin
                        sclk_q <= 1'b0;
                        mosi_q <= tx_q[15];
                        tx_q   <= {tx_q[14:0], 1'b0};
                    end
                end
            end else begin
                hc_q <= hc_q + 16'd1;
            end
        end
    end

    // Datapath registers
    logic [PWRUP_W-1:0]           pw_q;
    logic [1:0]                   cfg_idx_q;
    logic                         init_done_q;
    logic [2:0]                   bidx_q;
    logic [7:0]                   bytes_q [NBYTES];
    logic signed [AW-1:0]         acc_q   [NUM_AXES];
    logic signed [AW-1:0]         acc_sum [NUM_AXES];
    logic [4:0]                   smp_q;
    logic [NUM_AXES*16-1:0]       data_q;
    logic                         vld_q, ovr_q, ovr_d;
    logic                         pw_done, last_byte, win_wrap;

    assign pw_done   = &pw_q;
    assign last_byte = (bidx_q == BIDX_LAST);
    assign win_wrap  = (smp_q == SMP_LAST);

    always_comb begin
        for (int k = 0; k < NUM_AXES; k++) begin
            acc_sum[k] = acc_q[k] + AW'($signed({bytes_q[2*k+1], bytes_q[2*k]}));
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_PWRUP;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PWRUP: if (pw_done) state_d = S_CFG;
            S_CFG:   if (spi_done && cfg_idx_q == 2'd3) state_d = S_IDLE;
            S_IDLE:  if (int_edge && init_done_q) state_d = S_RD;
            S_RD:    if (spi_done && last_byte) state_d = S_ACC;
            S_ACC:   state_d = S_IDLE;
            default: state_d = S_PWRUP;
        endcase
    end

    // FSM: outputs (frame launches and overrun detect)
    logic [6:0] next_addr;
    always_comb begin
        start_frame = 1'b0;
        frame_word  = '0;
        next_addr   = AXIS_BASE + {4'b0, bidx_q} + 7'd1;
        ovr_d       = 1'b0;
        case (state_q)
            S_PWRUP: if (pw_done) begin
                start_frame = 1'b1;
                frame_word  = cfg_word(2'd0);
            end
            S_CFG: if (spi_done && cfg_idx_q != 2'd3) begin
                start_frame = 1'b1;
                frame_word  = cfg_word(cfg_idx_q + 2'd1);
            end
            S_IDLE: if (int_edge && init_done_q) begin
                start_frame = 1'b1;
                frame_word  = {1'b1, AXIS_BASE, 8'h00};
            end
            S_RD: begin
                ovr_d = int_edge;
                if (spi_done && !last_byte) begin
                    start_frame = 1'b1;
                    frame_word  = {1'b1, next_addr, 8'h00};
                end
            end
            S_ACC: ovr_d = int_edge;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_s1_q    <= 1'b0;
            int_s2_q    <= 1'b0;
            int_s3_q    <= 1'b0;
            pw_q        <= '0;
            cfg_idx_q   <= '0;
            init_done_q <= 1'b0;
            bidx_q      <= '0;
            smp_q       <= '0;
            data_q      <= '0;
            vld_q       <= 1'b0;
            ovr_q       <= 1'b0;
            for (int k = 0; k < NBYTES; k++)   bytes_q[k] <= '0;
            for (int k = 0; k < NUM_AXES; k++) acc_q[k]   <= '0;
        end else begin
            int_s1_q <= INT;
            int_s2_q <= int_s1_q;
            int_s3_q <= int_s2_q;
            vld_q    <= 1'b0;
            ovr_q    <= ovr_d;
            case (state_q)
                S_PWRUP: pw_q <= pw_q + 1'b1;
                S_CFG: if (spi_done) begin
                    cfg_idx_q <= cfg_idx_q + 2'd1;
                    if (cfg_idx_q == 2'd3) init_done_q <= 1'b1;
                end
                S_IDLE: bidx_q <= '0;
                S_RD: if (spi_done) begin
                    for (int k = 0; k < NBYTES; k++) begin
                        if (bidx_q == 3'(k)) bytes_q[k] <= rx_q[7:0];
                    end
                    bidx_q <= bidx_q + 3'd1;
                end
                S_ACC: begin
                    smp_q <= win_wrap ? 5'd0 : smp_q + 5'd1;
                    // Only complete windows reach data; arithmetic shift floors.
                    for (int k = 0; k < NUM_AXES; k++) begin
                        if (win_wrap) begin
                            data_q[16*k +: 16] <= 16'(acc_sum[k] >>> AVG_LOG2);
                            acc_q[k]           <= '0;
                        end else begin
                            acc_q[k] <= acc_sum[k];
                        end
                    end
                    vld_q <= win_wrap;
                end
                default: ;
            endcase
        end
    end

    assign SS_n      = ss_n_q;
    assign SCLK      = sclk_q;
    assign MOSI      = mosi_q;
    assign init_done = init_done_q;
    assign vld       = vld_q;
    assign data      = data_q;
    assign ovr       = ovr_q;

endmodule

// File: tb/tb_inert_intf_multi.sv
module tb_inert_intf_multi;

    localparam int NAX = 3;
    localparam int WIN = 4;          // 2^AVG_LOG2
    localparam int DW  = NAX * 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          INT = 1'b0;
    logic          MISO = 1'b0;
    logic          SS_n, SCLK, MOSI, init_done, vld, ovr;
    logic [DW-1:0] data;

    inert_intf_multi #(
        .NUM_AXES (NAX),
        .AXIS_BASE(7'h22),
        .AVG_LOG2 (2),
        .SCLK_DIV (8),
        .PWRUP_W  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .INT      (INT),
        .MISO     (MISO),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .init_done(init_done),
        .vld      (vld),
        .data     (data),
        .ovr      (ovr)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int            n_vec = 0;
    int            n_err = 0;
    logic [15:0]   exp_frame_q[$];
    logic [15:0]   got_frame_q[$];
    logic [DW-1:0] exp_q[$];
    int            ovr_seen = 0;
    int            exp_ovr = 0;
    int            frames_done = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // ---------------- sensor model ----------------
    logic [7:0]  regs [0:127];
    int          bit_cnt = 0;
    logic [15:0] sh = '0;
    logic [7:0]  cmd = '0;
    logic [2:0]  mi_bit;

    always @(posedge SCLK or posedge SS_n) begin
        if (SS_n === 1'b1) begin
            bit_cnt = 0;
        end else begin
            sh = {sh[14:0], MOSI};
            bit_cnt++;
            if (bit_cnt == 8) cmd = sh[7:0];
            if (bit_cnt == 16) begin
                got_frame_q.push_back(sh);
                frames_done++;
            end
        end
    end

    always @(negedge SCLK) begin
        if (SS_n === 1'b0 && bit_cnt >= 8 && cmd[7]) begin
            mi_bit = 3'(15 - bit_cnt);
            MISO = regs[cmd[6:0]][mi_bit];
        end else begin
            MISO = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    int            sum_m [NAX];
    int            n_m;
    logic [DW-1:0] last_data;

    task automatic model_reset();
        for (int k = 0; k < NAX; k++) sum_m[k] = 0;
        n_m = 0;
        last_data = '0;
    endtask

    task automatic set_axis(input int k, input logic [15:0] v);
        regs[34 + 2*k]     = v[7:0];
        regs[34 + 2*k + 1] = v[15:8];
    endtask

    // Expected SPI traffic (and, when counted, the sample) for one burst.
    task automatic issue_burst(input bit counted);
        logic signed [15:0] sv;
        logic [DW-1:0]      e;
        int                 q;
        for (int b = 0; b < 2*NAX; b++) exp_frame_q.push_back({1'b1, 7'(34 + b), 8'h00});
        if (counted) begin
            for (int k = 0; k < NAX; k++) begin
                sv = {regs[34 + 2*k + 1], regs[34 + 2*k]};
                sum_m[k] += int'(sv);
            end
            n_m++;
            if (n_m == WIN) begin
                e = '0;
                for (int k = 0; k < NAX; k++) begin
                    q = sum_m[k] / WIN;
                    if ((sum_m[k] % WIN) != 0 && sum_m[k] < 0) q = q - 1;
                    e[16*k +: 16] = 16'(q);
                    sum_m[k] = 0;
                end
                exp_q.push_back(e);
                last_data = e;
                n_m = 0;
            end
        end
    endtask

    // ---------------- monitor ----------------
    logic [15:0] mf;
    always @(negedge clk) begin
        if (ovr === 1'b1) ovr_seen++;
        if (vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL vld_unexpected: got data %h, expected no vld", data);
            end else begin
                check("vld_data", data, exp_q.pop_front());
            end
        end
        while (got_frame_q.size() > 0) begin
            mf = got_frame_q.pop_front();
            if (exp_frame_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spi_frame_unexpected: got %h, expected none", mf);
            end else begin
                check("spi_frame", mf, exp_frame_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fire_int();
        @(negedge clk);
        INT = 1'b1;
        repeat (4) @(negedge clk);
        INT = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (exp_frame_q.size() != 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_frames_left"}, exp_frame_q.size(), 0);
        repeat (24) @(negedge clk);
        check({name, "_vld_left"}, exp_q.size(), 0);
        check({name, "_data_hold"}, data, last_data);
    endtask

    task automatic do_reset(input bit toggle_int);
        int cnt = 0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_pins", {SS_n, SCLK, MOSI, init_done, vld, ovr}, 6'b110000);
        check("rst_data", data, 0);
        exp_frame_q.delete();
        exp_q.delete();
        model_reset();
        exp_frame_q.push_back(16'h0D02);
        exp_frame_q.push_back(16'h1053);
        exp_frame_q.push_back(16'h1150);
        exp_frame_q.push_back(16'h1460);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        while (SS_n !== 1'b0 && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
            if (toggle_int) INT = ((cnt % 4) >= 2);
        end
        check("pwrup_cycles", cnt, 16);
        check("init_low_in_cfg", init_done, 0);
        INT = 1'b0;
        if (toggle_int) repeat (5) fire_int();
        wait_idle("config");
        check("init_done", init_done, 1);
    endtask

    task automatic run_burst(input string name);
        issue_burst(1'b1);
        fire_int();
        wait_idle(name);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        int f0;
        for (int a = 0; a < 128; a++) regs[a] = 8'h00;
        model_reset();

        // Reset, power-up timing, config sequence, INT ignored before init
        do_reset(1'b1);
        check("preinit_ovr", ovr_seen, exp_ovr);

        // Burst read of a known register image, averaged over a full window
        regs[34] = 8'h34; regs[35] = 8'h12; regs[36] = 8'hCD;
        regs[37] = 8'hAB; regs[38] = 8'h00; regs[39] = 8'h80;
        for (int i = 0; i < WIN; i++) run_burst("burst");
        check("burst_data", data, 48'h8000_ABCD_1234);

        // Averaging: 4,8,12,16 -> 10
        for (int i = 0; i < WIN; i++) begin
            set_axis(0, 16'(4 * (i + 1)));
            set_axis(1, 16'($urandom_range(0, 65535)));
            set_axis(2, 16'($urandom_range(0, 65535)));
            run_burst("avg_pos");
        end
        check("avg_pos_axis0", data[15:0], 16'd10);

        // Averaging with floor: -4,-4,-4,-3 -> -4
        for (int i = 0; i < WIN; i++) begin
            set_axis(0, (i == 3) ? 16'hFFFD : 16'hFFFC);
            run_burst("avg_neg");
        end
        check("avg_neg_axis0", data[15:0], 16'hFFFC);

        // Overrun: second INT edge during the 3rd frame of the window-closing burst
        for (int i = 0; i < WIN - 1; i++) run_burst("pre_ovr");
        issue_burst(1'b1);
        f0 = frames_done;
        fire_int();
        t = 0;
        while (frames_done < f0 + 2 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("ovr_wait_bound", (t < 5000), 1);
        repeat (20) @(negedge clk);
        exp_ovr++;
        fire_int();
        wait_idle("overrun");
        repeat (300) @(negedge clk);
        check("ovr_count", ovr_seen, exp_ovr);
        check("ovr_no_extra_frames", got_frame_q.size() + exp_frame_q.size(), 0);

        // Reset in the middle of a read frame
        issue_burst(1'b0);
        fire_int();
        t = 0;
        while (!(SS_n === 1'b0 && bit_cnt == 7 && SCLK === 1'b0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("midframe_wait_bound", (t < 5000), 1);
        do_reset(1'b0);
        run_burst("after_reset");

        // Randomized register images
        for (int i = 0; i < 16; i++) begin
            for (int a = 34; a < 34 + 2*NAX; a++) regs[a] = 8'($urandom_range(0, 255));
            run_burst("random");
        end

        check("final_ovr", ovr_seen, exp_ovr);
        check("final_frames", exp_frame_q.size(), 0);
        check("final_vld", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, expected finish before 900000 ns");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

endmodule
